axis_tsc_capture: RTL and testbench
===================================

Name: axis_tsc_capture

Overview:
Timestamp consumer at the receiving end of the free-running counter stream. It accepts the AXI4-Stream counter word on its slave port and, on each rising edge of trg_flag, latches the current count into an internal FIFO. Captured stamps go out on an AXI4-Stream master port with full handshake, for a DMA writer or register reader. It sits next to trigger/event logic and gives each event a cycle-accurate time tag.

Parameters:
AXIS_TDATA_WIDTH, 64, width of s_axis_tdata and m_axis_tdata.
CNTR_WIDTH, 48, significant counter bits; must be at most AXIS_TDATA_WIDTH.
FIFO_ADDR_WIDTH, 4, log2 of FIFO depth; default depth 16.
LOST_WIDTH, 32, width of the dropped-event counter.

Ports:
aclk  in  1  clock.
aresetn  in  1  synchronous reset, active-low.
trg_flag  in  1  event level, synchronous to aclk; a rising edge is one event.
s_axis_tdata  in  AXIS_TDATA_WIDTH  counter stream; only bits [CNTR_WIDTH-1:0] are used.
s_axis_tvalid  in  1  counter word valid.
s_axis_tready  out  1  always 1.
m_axis_tdata  out  AXIS_TDATA_WIDTH  captured stamp, zero-extended from CNTR_WIDTH.
m_axis_tvalid  out  1  FIFO not empty.
m_axis_tready  in  1  downstream accept.
fifo_count  out  FIFO_ADDR_WIDTH+1  number of stored stamps, 0..2^FIFO_ADDR_WIDTH.
lost_cntr  out  LOST_WIDTH  events dropped, saturating.

Behaviour:
- Reset (aresetn=0 at a posedge) clears FIFO pointers, fifo_count=0, m_axis_tvalid=0, lost_cntr=0, ts_valid=0, ts_reg=0.
- Reset sets trg_reg=1, so a trigger already high when reset is released is not an event.
- Reset mid-operation discards all stored stamps. FIFO RAM contents are don't-care.
- s_axis_tready is tied to 1. Input is never back-pressured.
- Each cycle with s_axis_tvalid=1: ts_reg <= s_axis_tdata[CNTR_WIDTH-1:0] and ts_valid <= 1.
- Edge detect: trg_reg <= trg_flag every cycle. An event is trg_flag & ~trg_reg.
- Stamp value on an event cycle:
  - s_axis_tdata[CNTR_WIDTH-1:0] if s_axis_tvalid=1 in that cycle;
  - otherwise ts_reg.
  - The stamp equals the counter word present in the same cycle as the edge. Trigger-to-stamp skew is 0.
- Events that cannot be stored:
  - Event with ts_valid=0 and s_axis_tvalid=0 (no count yet): dropped, lost_cntr increments.
  - Event when fifo_count = 2^FIFO_ADDR_WIDTH and no pop in the same cycle: dropped, lost_cntr increments.
  - Event when full with a pop in the same cycle: accepted; fifo_count stays full.
- lost_cntr saturates at all-ones and never wraps.
- Pop happens when m_axis_tvalid & m_axis_tready.
- FIFO is first-word-fall-through: m_axis_tdata shows the head entry whenever m_axis_tvalid=1.
- m_axis_tdata and m_axis_tvalid hold stable while tvalid=1 and tready=0.
- Latency: event at posedge N is visible on m_axis_tvalid/m_axis_tdata after posedge N+1, i.e. a 1-cycle write-through delay. An empty FIFO does not bypass.
- fifo_count: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- Pointers are FIFO_ADDR_WIDTH bits and wrap modulo depth. Full/empty come from fifo_count.
- Upper AXIS_TDATA_WIDTH-CNTR_WIDTH bits of m_axis_tdata are always 0.
- If CNTR_WIDTH = AXIS_TDATA_WIDTH, there is no padding.

Test Plan:
- Reset, then counter stream 0,1,2… with tvalid=1 and trg_flag held high through reset release -> no stamp, lost_cntr=0, fifo_count=0.
- Single edge when input count=0x000000001234, m_axis_tready=1 -> next cycle m_axis_tvalid=1 with m_axis_tdata=0x0000000000001234. Popped the following cycle; fifo_count returns to 0.
- m_axis_tready=0, 20 edges spaced 3 cycles apart starting at count 100 -> fifo_count=16 holding 100,103,…,145. lost_cntr=4. Draining returns exactly those 16 values in order.
- FIFO full with m_axis_tready=1 and an edge in the same cycle -> event accepted, fifo_count stays 16, lost_cntr unchanged.
- s_axis_tvalid pulled low after count 500, edge 2 cycles later -> stamp=500. An edge before any valid input after reset -> dropped, lost_cntr=1.
- 5 stamps stored, aresetn low for 1 cycle -> m_axis_tvalid=0, fifo_count=0, lost_cntr=0. The next edge after release produces a fresh stamp.

Source files
------------

// File: rtl/axis_tsc_capture.sv
// Event timestamp capture for a free-running AXI4-Stream counter.
// Each rising edge of trg_flag stores the counter word seen in the same
// cycle into a first-word-fall-through FIFO that drains on an AXI4-Stream
// master port. Events that cannot be stored are counted in lost_cntr.
//
// Ports:
//   aclk, aresetn   clock, synchronous active-low reset
//   trg_flag        event level; a rising edge is one event
//   s_axis_*        counter stream in (tready tied high)
//   m_axis_*        captured stamps out, zero-extended from CNTR_WIDTH
//   fifo_count      stored stamps, 0..2^FIFO_ADDR_WIDTH
//   lost_cntr       dropped events, saturating
module axis_tsc_capture #(
   parameter int unsigned AXIS_TDATA_WIDTH = 64,
   parameter int unsigned CNTR_WIDTH       = 48,
   parameter int unsigned FIFO_ADDR_WIDTH  = 4,
   parameter int unsigned LOST_WIDTH       = 32
) (
   input  logic                        aclk,
   input  logic                        aresetn,
   input  logic                        trg_flag,
   input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
   input  logic                        s_axis_tvalid,
   output logic                        s_axis_tready,
   output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
   output logic                        m_axis_tvalid,
   input  logic                        m_axis_tready,
   output logic [FIFO_ADDR_WIDTH:0]    fifo_count,
   output logic [LOST_WIDTH-1:0]       lost_cntr
);

   localparam int unsigned DEPTH    = 2 ** FIFO_ADDR_WIDTH;
   localparam int unsigned CNT_W    = FIFO_ADDR_WIDTH + 1;
   localparam logic [FIFO_ADDR_WIDTH-1:0] PTR_ONE  = FIFO_ADDR_WIDTH'(1);
   localparam logic [CNT_W-1:0]           CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0]           CNT_FULL = CNT_W'(DEPTH);
   localparam logic [LOST_WIDTH-1:0]      LOST_ONE = LOST_WIDTH'(1);

   logic                       trg_reg;
   logic                       ts_valid;
   logic [CNTR_WIDTH-1:0]      ts_reg;
   logic [CNTR_WIDTH-1:0]      mem [DEPTH];
   logic [FIFO_ADDR_WIDTH-1:0] wr_ptr;
   logic [FIFO_ADDR_WIDTH-1:0] rd_ptr;

   logic                  event_c;
   logic                  pop_c;
   logic                  push_c;
   logic                  drop_c;
   logic [CNTR_WIDTH-1:0] stamp_c;
   logic [CNT_W-1:0]      count_nxt_c;

   assign s_axis_tready = 1'b1;

   // Head of the FIFO is always presented (first-word-fall-through).
   assign m_axis_tdata = AXIS_TDATA_WIDTH'(mem[rd_ptr]);

   // Counter bits above CNTR_WIDTH carry no timing information.
   if (AXIS_TDATA_WIDTH > CNTR_WIDTH) begin : g_pad
      logic unused_upper;
      assign unused_upper = ^s_axis_tdata[AXIS_TDATA_WIDTH-1:CNTR_WIDTH];
   end

   // Event qualification and FIFO occupancy update.
   always_comb begin
      event_c     = 1'b0;
      pop_c       = 1'b0;
      push_c      = 1'b0;
      drop_c      = 1'b0;
      stamp_c     = ts_reg;
      count_nxt_c = fifo_count;

      event_c = trg_flag & ~trg_reg;
      pop_c   = m_axis_tvalid & m_axis_tready;
      // Zero skew: use the word arriving in the edge cycle when there is one.
      if (s_axis_tvalid) begin
         stamp_c = s_axis_tdata[CNTR_WIDTH-1:0];
      end
      // A full FIFO still takes the event if the head leaves in the same cycle.
      push_c = event_c & (ts_valid | s_axis_tvalid) & ((fifo_count != CNT_FULL) | pop_c);
      drop_c = event_c & ~push_c;

      case ({push_c, pop_c})
         2'b10:   count_nxt_c = fifo_count + CNT_ONE;
         2'b01:   count_nxt_c = fifo_count - CNT_ONE;
         default: count_nxt_c = fifo_count;
      endcase
   end

   // Control state, pointers and status counters.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         trg_reg       <= 1'b1;
         ts_valid      <= 1'b0;
         ts_reg        <= '0;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         fifo_count    <= '0;
         m_axis_tvalid <= 1'b0;
         lost_cntr     <= '0;
      end else begin
         trg_reg <= trg_flag;
         if (s_axis_tvalid) begin
            ts_reg   <= s_axis_tdata[CNTR_WIDTH-1:0];
            ts_valid <= 1'b1;
         end
         if (push_c) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop_c) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         fifo_count    <= count_nxt_c;
         m_axis_tvalid <= (count_nxt_c != '0);
         if (drop_c && (lost_cntr != '1)) begin
            lost_cntr <= lost_cntr + LOST_ONE;
         end
      end
   end

   // Stamp storage; contents need no reset.
   always_ff @(posedge aclk) begin
      if (push_c) begin
         mem[wr_ptr] <= stamp_c;
      end
   end

endmodule

// File: tb/tb_axis_tsc_capture.sv
// Testbench for axis_tsc_capture: directed test-plan scenarios followed by
// randomized traffic, checked by a queue-based reference model and a
// scoreboard monitor on the master port.
module tb_axis_tsc_capture;

   localparam int unsigned DW    = 64;
   localparam int unsigned CW    = 48;
   localparam int unsigned AW    = 4;
   localparam int unsigned LW    = 32;
   localparam int unsigned DEPTH = 16;

   logic          aclk = 1'b0;
   logic          aresetn = 1'b0;
   logic          trg_flag = 1'b0;
   logic [DW-1:0] s_axis_tdata = '0;
   logic          s_axis_tvalid = 1'b0;
   logic          s_axis_tready;
   logic [DW-1:0] m_axis_tdata;
   logic          m_axis_tvalid;
   logic          m_axis_tready = 1'b0;
   logic [AW:0]   fifo_count;
   logic [LW-1:0] lost_cntr;

   int nchk = 0;
   int nerr = 0;
   bit mon_en = 1'b0;

   // Reference model state: stamps owed to the output, occupancy, losses.
   logic [CW-1:0] sb_q[$];
   int            mcnt = 0;
   logic [LW-1:0] mlost = '0;
   bit            mtsv = 1'b0;
   bit            mprev = 1'b1;
   logic [CW-1:0] mts = '0;
   logic [CW-1:0] ctr = '0;

   axis_tsc_capture #(
      .AXIS_TDATA_WIDTH(DW),
      .CNTR_WIDTH      (CW),
      .FIFO_ADDR_WIDTH (AW),
      .LOST_WIDTH      (LW)
   ) dut (
      .aclk         (aclk),
      .aresetn      (aresetn),
      .trg_flag     (trg_flag),
      .s_axis_tdata (s_axis_tdata),
      .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(s_axis_tready),
      .m_axis_tdata (m_axis_tdata),
      .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready),
      .fifo_count   (fifo_count),
      .lost_cntr    (lost_cntr)
   );

   always #5 aclk = ~aclk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock of stimulus; the counter advances every cycle, upper bits are junk.
   task automatic cyc(input bit trg, input bit sv, input bit rdy);
      @(posedge aclk);
      #1;
      trg_flag      = trg;
      s_axis_tvalid = sv;
      m_axis_tready = rdy;
      s_axis_tdata  = {16'($urandom), ctr};
      ctr           = ctr + 48'd1;
   endtask

   // Behavioural model: events become queued stamps unless there is no time
   // yet or no room (room exists when the head is leaving this cycle).
   always @(posedge aclk) begin
      bit ev;
      bit pop;
      if (!aresetn) begin
         sb_q.delete();
         mcnt  = 0;
         mlost = '0;
         mtsv  = 1'b0;
         mts   = '0;
         mprev = 1'b1;
      end else begin
         ev  = trg_flag && !mprev;
         pop = (mcnt > 0) && m_axis_tready;
         if (ev) begin
            if ((mtsv || s_axis_tvalid) && (mcnt < DEPTH || pop)) begin
               sb_q.push_back(s_axis_tvalid ? s_axis_tdata[CW-1:0] : mts);
               mcnt++;
            end else if (mlost != '1) begin
               mlost = mlost + 32'd1;
            end
         end
         if (pop) mcnt--;
         if (s_axis_tvalid) begin
            mts  = s_axis_tdata[CW-1:0];
            mtsv = 1'b1;
         end
         mprev = trg_flag;
      end
   end

   // Monitor: status every cycle, data on each handshake against the scoreboard.
   always @(negedge aclk) begin
      if (mon_en) begin
         chk("m_axis_tvalid", 64'(m_axis_tvalid), 64'(mcnt > 0));
         chk("fifo_count", 64'(fifo_count), 64'(mcnt));
         chk("lost_cntr", 64'(lost_cntr), 64'(mlost));
         chk("s_axis_tready", 64'(s_axis_tready), 64'd1);
         if (aresetn && m_axis_tvalid && m_axis_tready) begin
            if (sb_q.size() == 0) begin
               nchk++;
               nerr++;
               $display("FAIL m_axis_tdata: got 0x%0h expected no output at %0t", m_axis_tdata, $time);
            end else begin
               chk("m_axis_tdata", m_axis_tdata, {16'h0, sb_q.pop_front()});
            end
         end
      end
   end

   initial begin
      logic [CW-1:0] saved;
      bit            r;

      // Trigger held high through reset release is not an event.
      aresetn = 1'b0;
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0);
      mon_en  = 1'b1;
      aresetn = 1'b1;
      for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b1);
      @(negedge aclk);
      chk("hi_through_reset count", 64'(fifo_count), 64'd0);
      chk("hi_through_reset lost", 64'(lost_cntr), 64'd0);
      chk("hi_through_reset tvalid", 64'(m_axis_tvalid), 64'd0);

      // Single edge at count 0x1234.
      ctr = 48'h1230;
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b1);
      cyc(1'b1, 1'b1, 1'b1);
      cyc(1'b1, 1'b1, 1'b1);
      @(negedge aclk);
      chk("single tvalid", 64'(m_axis_tvalid), 64'd1);
      chk("single tdata", m_axis_tdata, 64'h1234);
      cyc(1'b0, 1'b1, 1'b1);
      @(negedge aclk);
      chk("single drained", 64'(fifo_count), 64'd0);

      // 20 events with no drain: 16 stored, 4 lost.
      ctr = 48'd100;
      for (int i = 0; i < 20; i++) begin
         cyc(1'b1, 1'b1, 1'b0);
         cyc(1'b0, 1'b1, 1'b0);
         cyc(1'b0, 1'b1, 1'b0);
      end
      cyc(1'b0, 1'b1, 1'b0);
      @(negedge aclk);
      chk("overflow count", 64'(fifo_count), 64'd16);
      chk("overflow lost", 64'(lost_cntr), 64'd4);
      for (int i = 0; i < 16; i++) begin
         cyc(1'b0, 1'b1, 1'b1);
         @(negedge aclk);
         chk("drain order", m_axis_tdata, 64'(100 + 3 * i));
      end
      cyc(1'b0, 1'b1, 1'b0);
      @(negedge aclk);
      chk("drain empty", 64'(fifo_count), 64'd0);

      // Full FIFO with pop and event together: accepted, stays full.
      for (int i = 0; i < 16; i++) begin
         cyc(1'b1, 1'b1, 1'b0);
         cyc(1'b0, 1'b1, 1'b0);
      end
      cyc(1'b0, 1'b1, 1'b0);
      @(negedge aclk);
      chk("refill count", 64'(fifo_count), 64'd16);
      cyc(1'b1, 1'b1, 1'b1);
      cyc(1'b0, 1'b1, 1'b0);
      @(negedge aclk);
      chk("full+pop count", 64'(fifo_count), 64'd16);
      chk("full+pop lost", 64'(lost_cntr), 64'd4);
      for (int i = 0; i < 18; i++) cyc(1'b0, 1'b1, 1'b1);

      // Edge before any valid count after reset is dropped.
      aresetn = 1'b0;
      cyc(1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b1);
      aresetn = 1'b1;
      cyc(1'b0, 1'b0, 1'b1);
      cyc(1'b1, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b1);
      @(negedge aclk);
      chk("no_count lost", 64'(lost_cntr), 64'd1);
      chk("no_count count", 64'(fifo_count), 64'd0);

      // Stream stalls after 500; edge two cycles later uses the held count.
      ctr = 48'd497;
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b1);
      cyc(1'b0, 1'b0, 1'b1);
      cyc(1'b1, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b1);
      @(negedge aclk);
      chk("held tvalid", 64'(m_axis_tvalid), 64'd1);
      chk("held tdata", m_axis_tdata, 64'd500);

      // Reset discards stored stamps; next edge gives a fresh one.
      for (int i = 0; i < 5; i++) begin
         cyc(1'b1, 1'b1, 1'b0);
         cyc(1'b0, 1'b1, 1'b0);
      end
      cyc(1'b0, 1'b1, 1'b0);
      @(negedge aclk);
      chk("pre_reset count", 64'(fifo_count), 64'd5);
      aresetn = 1'b0;
      cyc(1'b0, 1'b1, 1'b0);
      aresetn = 1'b1;
      @(negedge aclk);
      chk("mid_reset tvalid", 64'(m_axis_tvalid), 64'd0);
      chk("mid_reset count", 64'(fifo_count), 64'd0);
      chk("mid_reset lost", 64'(lost_cntr), 64'd0);
      cyc(1'b0, 1'b1, 1'b0);
      saved = ctr;
      cyc(1'b1, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b0);
      @(negedge aclk);
      chk("post_reset tdata", m_axis_tdata, {16'h0, saved});

      // Randomized traffic alternating slow and fast drain phases.
      for (int i = 0; i < 2000; i++) begin
         if ((i / 250) % 2 == 1) r = ($urandom % 8 == 0);
         else                    r = ($urandom % 4 != 0);
         aresetn = ($urandom % 400 != 0);
         if ($urandom % 100 == 0) ctr = 48'($urandom) << 16;
         cyc($urandom % 3 == 0, $urandom % 5 != 0, r);
      end
      aresetn = 1'b1;
      for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 1'b1);
      @(negedge aclk);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
